// File: rtl/uart_arb_if.sv
// uart_arb_if: byte sources, uart handshake and status seen by the UART arbiter.
interface uart_arb_if #(parameter int FIFO_AW = 4);
    logic [7:0]       a_data;
    logic             a_valid;
    logic [7:0]       b_data;
    logic             b_req;
    logic             b_ack;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_busy;
    logic [FIFO_AW:0] fifo_level;
    logic [7:0]       drop_cnt;
    modport master (
        output a_data, a_valid, b_data, b_req, tx_busy,
        input  b_ack, tx_data, tx_valid, fifo_level, drop_cnt
    );
    modport slave (
        input  a_data, a_valid, b_data, b_req, tx_busy,
        output b_ack, tx_data, tx_valid, fifo_level, drop_cnt
    );
endinterface

// File: rtl/uart_arb.sv
// uart_arb: FIFO-buffers LPC bytes and round-robins them with requester B onto the shared UART.
module uart_arb #(
    parameter int FIFO_AW = 4
) (
    input logic      LPC_CLK,
    input logic      LPC_RST,
    uart_arb_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    typedef enum logic [1:0] {IDLE, SEND, GAP, WAIT} state_t;
    state_t             state, state_nx;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wp, rp;
    logic [FIFO_AW:0]   level;
    logic [7:0]         drop, tx_data;
    logic               last, b_ack, grant_a, grant_b, push;
    // last=1 means B was served most recently, so A wins the next tie
    always_comb begin
        state_nx = state;
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        case (state)
            IDLE: begin
                grant_a  = level != '0 && (!bus.b_req || last);
                grant_b  = bus.b_req && (level == '0 || !last);
                state_nx = (grant_a || grant_b) ? SEND : IDLE;
            end
            SEND:    state_nx = GAP;
            GAP:     state_nx = WAIT;
            default: state_nx = bus.tx_busy ? WAIT : IDLE;
        endcase
    end
    // a full FIFO still accepts a byte when the head leaves on the same edge
    assign push = bus.a_valid && (level != (FIFO_AW+1)'(DEPTH) || grant_a);
    always_ff @(posedge LPC_CLK or posedge LPC_RST) begin
        if (LPC_RST) begin
            state   <= IDLE;
            wp      <= '0;
            rp      <= '0;
            level   <= '0;
            drop    <= '0;
            tx_data <= '0;
            b_ack   <= 1'b0;
            last    <= 1'b1;
        end else begin
            state <= state_nx;
            b_ack <= grant_b;
            level <= level + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(grant_a);
            if (push) wp <= wp + 1'b1;
            if (grant_a) rp <= rp + 1'b1;
            if (bus.a_valid && !push && drop != 8'hFF) drop <= drop + 8'd1;
            if (grant_a || grant_b) begin
                tx_data <= grant_a ? mem[rp] : bus.b_data;
                last    <= grant_b;
            end
        end
    end
    always_ff @(posedge LPC_CLK) begin
        if (push) mem[wp] <= bus.a_data;
    end
    assign bus.tx_valid   = state == SEND;
    assign bus.tx_data    = tx_data;
    assign bus.b_ack      = b_ack;
    assign bus.fifo_level = level;
    assign bus.drop_cnt   = drop;
endmodule

// File: tb/tb_uart_arb.sv
// tb_uart_arb: directed checks of FIFO buffering, arbitration, uart pacing and reset.
module tb_uart_arb;
    logic LPC_CLK = 1'b0;
    logic LPC_RST = 1'b1;
    logic busy_man = 1'b0;
    logic busy_model = 1'b0;
    logic model_en = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   mstart = -100;
    int   n_ack = 0;
    int   n_viol = 0;
    int   txq[$];
    int   tq[$];
    uart_arb_if #(.FIFO_AW(4)) bus ();
    uart_arb #(.FIFO_AW(4)) dut (.LPC_CLK(LPC_CLK), .LPC_RST(LPC_RST), .bus(bus.slave));
    assign bus.tx_busy = busy_man | busy_model;
    always #5 LPC_CLK = ~LPC_CLK;
    always @(posedge LPC_CLK) cyc <= cyc + 1;
    // uart model: busy for 10 cycles starting one cycle after each start strobe
    always @(negedge LPC_CLK) begin
        busy_model = model_en && cyc >= mstart + 1 && cyc <= mstart + 10;
        if (bus.tx_valid) begin
            txq.push_back(int'(bus.tx_data));
            tq.push_back(cyc);
            if (busy_model) n_viol++;
            if (model_en) mstart = cyc;
        end
        if (bus.b_ack) n_ack++;
    end
    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic do_reset();
        LPC_RST = 1'b1;
        bus.a_valid = 1'b0;
        bus.a_data = '0;
        bus.b_req = 1'b0;
        bus.b_data = '0;
        busy_man = 1'b0;
        model_en = 1'b0;
        repeat (2) @(negedge LPC_CLK);
        LPC_RST = 1'b0;
    endtask
    task automatic wait_tx(input int n, input int limit);
        for (int i = 0; i < limit && txq.size() < n; i++) @(negedge LPC_CLK);
        repeat (2) @(negedge LPC_CLK);
    endtask
    // park the FSM in WAIT with uart stuck busy, by serving a B byte
    task automatic park_busy();
        busy_man = 1'b1;
        bus.b_req = 1'b1;
        bus.b_data = 8'hEE;
        @(negedge LPC_CLK);
        bus.b_req = 1'b0;
        repeat (3) @(negedge LPC_CLK);
    endtask
    int base, t0, a0, sp;
    initial begin
        do_reset();
        check("rst_tx_valid", int'(bus.tx_valid), 0);
        check("rst_level", int'(bus.fifo_level), 0);
        check("rst_drop", int'(bus.drop_cnt), 0);
        check("rst_b_ack", int'(bus.b_ack), 0);
        check("rst_tx_data", int'(bus.tx_data), 0);

        base = txq.size();
        bus.a_valid = 1'b1;
        bus.a_data = 8'h80;
        t0 = cyc;
        @(negedge LPC_CLK);
        bus.a_valid = 1'b0;
        check("single_level1", int'(bus.fifo_level), 1);
        repeat (10) @(negedge LPC_CLK);
        check("single_count", txq.size() - base, 1);
        check("single_data", (txq.size() > base) ? txq[base] : -1, 8'h80);
        check("single_latency", (tq.size() > base) ? tq[base] - t0 : -1, 2);
        check("single_level0", int'(bus.fifo_level), 0);

        do_reset();
        base = txq.size();
        park_busy();
        for (int i = 0; i < 20; i++) begin
            bus.a_valid = 1'b1;
            bus.a_data = 8'(i);
            @(negedge LPC_CLK);
        end
        bus.a_valid = 1'b0;
        check("burst_level", int'(bus.fifo_level), 16);
        check("burst_drop", int'(bus.drop_cnt), 4);
        busy_man = 1'b0;
        wait_tx(base + 17, 300);
        check("burst_count", txq.size() - base, 17);
        check("burst_first", (txq.size() > base) ? txq[base] : -1, 8'hEE);
        for (int i = 0; i < 16; i++)
            check($sformatf("burst_byte%0d", i), (txq.size() > base + 1 + i) ? txq[base + 1 + i] : -1, i);
        check("burst_level_end", int'(bus.fifo_level), 0);

        do_reset();
        base = txq.size();
        a0 = n_ack;
        bus.a_valid = 1'b1;
        bus.a_data = 8'hAA;
        @(negedge LPC_CLK);
        bus.a_data = 8'hBB;
        bus.b_req = 1'b1;
        bus.b_data = 8'h55;
        @(negedge LPC_CLK);
        bus.a_valid = 1'b0;
        for (int i = 0; i < 100 && txq.size() < base + 3; i++) begin
            if (bus.b_ack) bus.b_req = 1'b0;
            @(negedge LPC_CLK);
        end
        bus.b_req = 1'b0;
        repeat (4) @(negedge LPC_CLK);
        check("arb_count", txq.size() - base, 3);
        check("arb_first", (txq.size() > base) ? txq[base] : -1, 8'hAA);
        check("arb_second", (txq.size() > base + 1) ? txq[base + 1] : -1, 8'h55);
        check("arb_third", (txq.size() > base + 2) ? txq[base + 2] : -1, 8'hBB);
        check("arb_acks", n_ack - a0, 1);

        do_reset();
        model_en = 1'b1;
        base = txq.size();
        a0 = n_viol;
        for (int i = 0; i < 3; i++) begin
            bus.a_valid = 1'b1;
            bus.a_data = 8'(8'h11 * (i + 1));
            @(negedge LPC_CLK);
        end
        bus.a_valid = 1'b0;
        wait_tx(base + 3, 200);
        check("pace_count", txq.size() - base, 3);
        check("pace_violations", n_viol - a0, 0);
        for (int i = 0; i < 2; i++) begin
            sp = (tq.size() > base + 1 + i) ? tq[base + 1 + i] - tq[base + i] : -1;
            check($sformatf("pace_gap%0d_min", i), int'(sp >= 12), 1);
            check($sformatf("pace_gap%0d", i), sp, 13);
        end
        check("pace_data_last", (txq.size() > base + 2) ? txq[base + 2] : -1, 8'h33);

        do_reset();
        park_busy();
        for (int i = 0; i < 316; i++) begin
            bus.a_valid = 1'b1;
            bus.a_data = 8'(i);
            @(negedge LPC_CLK);
            if (i == 115) check("sat_drop100", int'(bus.drop_cnt), 100);
        end
        bus.a_valid = 1'b0;
        check("sat_drop", int'(bus.drop_cnt), 255);
        check("sat_level", int'(bus.fifo_level), 16);

        do_reset();
        park_busy();
        for (int i = 0; i < 5; i++) begin
            bus.a_valid = 1'b1;
            bus.a_data = 8'(i + 1);
            @(negedge LPC_CLK);
        end
        bus.a_valid = 1'b0;
        @(negedge LPC_CLK);
        check("mid_level", int'(bus.fifo_level), 5);
        check("mid_tx_data", int'(bus.tx_data), 8'hEE);
        #2 LPC_RST = 1'b1;
        #1;
        check("arst_tx_valid", int'(bus.tx_valid), 0);
        check("arst_level", int'(bus.fifo_level), 0);
        check("arst_drop", int'(bus.drop_cnt), 0);
        check("arst_b_ack", int'(bus.b_ack), 0);
        check("arst_tx_data", int'(bus.tx_data), 0);
        @(negedge LPC_CLK);
        busy_man = 1'b0;
        LPC_RST = 1'b0;
        base = txq.size();
        bus.a_valid = 1'b1;
        bus.a_data = 8'h5A;
        t0 = cyc;
        @(negedge LPC_CLK);
        bus.a_valid = 1'b0;
        repeat (10) @(negedge LPC_CLK);
        check("post_count", txq.size() - base, 1);
        check("post_data", (txq.size() > base) ? txq[base] : -1, 8'h5A);
        check("post_latency", (tq.size() > base) ? tq[base] - t0 : -1, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
